button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Per-button synchroniser, debouncer and press-event latch between the raw board buttons (L/rotate/R)
//  and the cell-storage movement logic. Emits clean levels, single-cycle press pulses and sticky
//  press-pending flags held until the consumer acknowledges, so no press is lost while the core is busy.
// PARAMETERS
//  N_BTN            3        number of buttons (bit0=L, bit1=rotate, bit2=R)
//  SYNC_STAGES      2        flip-flop synchroniser depth (>=2)
//  DEBOUNCE_CYCLES  251750   consecutive stable cycles needed to accept a level change (~10 ms @25.175 MHz)
//  BTN_ACTIVE_LOW   0        1: raw pin low = pressed (inverted right after synchroniser)
//  REPEAT_DELAY     6293750  held cycles before first auto-repeat (~250 ms); used only with AUTOREPEAT_EN
//  REPEAT_PERIOD    2517500  cycles between subsequent repeats (~100 ms); used only with AUTOREPEAT_EN
//  CNT_W            $clog2 of max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1; derived, do not override
// PORTS
//  clk_25_175     in   1      pixel/system clock; the only clock
//  reset          in   1      asynchronous, active-high reset
//  btn_raw        in   N_BTN  raw asynchronous button pins
//  btn_level      out  N_BTN  debounced pressed level
//  btn_press      out  N_BTN  1-cycle pulse per accepted press (and per repeat when enabled)
//  press_pending  out  N_BTN  sticky flag, set by btn_press, cleared by press_ack
//  press_ack      in   N_BTN  consumer acknowledge, 1-cycle, per bit
// BEHAVIOUR
//  - Reset (async assert, sync deassert by design of upstream reset gen): all sync flops, counters,
//    btn_level, btn_press, press_pending = 0; every channel FSM in IDLE. Reset mid-debounce discards it.
//  - Sync: SYNC_STAGES flops per bit; polarity fix applied at synchroniser output (s_i).
//  - Channel FSM (independent per bit): IDLE -> PRESS_WAIT when s_i=1; PRESS_WAIT counts cycles with s_i=1,
//    any s_i=0 returns to IDLE with counter cleared; on count reaching DEBOUNCE_CYCLES -> HELD.
//    HELD -> RELEASE_WAIT when s_i=0; RELEASE_WAIT mirrors PRESS_WAIT, returns to HELD on bounce,
//    -> IDLE after DEBOUNCE_CYCLES consecutive zeros.
//  - btn_level=1 in HELD and RELEASE_WAIT. btn_press=1 exactly in the first cycle btn_level reads 1.
//  - Latency: clean raw rising edge at cycle 0 -> btn_press high in cycle SYNC_STAGES+DEBOUNCE_CYCLES.
//    Release latency identical for btn_level falling.
//  - Counters saturate; never wrap. Width CNT_W guarantees no overflow.
//  - press_pending[i]: next = btn_press[i] | (press_pending[i] & ~press_ack[i]). Simultaneous press and
//    ack -> stays 1 (new event wins). Ack while pending=0 is ignored. Multiple presses before ack merge.
//  - Buttons are fully independent; simultaneous presses produce simultaneous pulses.
// CONFIGURATION
//  AUTOREPEAT_EN defined: in HELD a repeat counter runs; after REPEAT_DELAY cycles btn_press pulses again,
//    then every REPEAT_PERIOD cycles while still HELD; counter cleared on leaving HELD. RELEASE_WAIT
//    freezes the repeat counter (bounce on release does not trigger repeats).
//  AUTOREPEAT_EN undefined: exactly one btn_press per accepted press; repeat counter and params unused.
// STRUCTURE
//  - Shared package tetris_input_pkg: channel state enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT},
//    button index constants BTN_L=0, BTN_ROT=1, BTN_R=2, default timing constants.
//  - Sub-module btn_debounce_ch: one channel (sync, FSM, debounce/repeat counters, pulse, pending);
//    button_conditioner generates N_BTN instances and concatenates outputs.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, SYNC_STAGES=2)
//  1 Clean press: btn_raw[0] 0->1 at cycle 0, held -> btn_press[0] high only in cycle 6, btn_level[0]=1
//    from 6, press_pending[0]=1 from 7 until ack.
//  2 Bounce: raw toggles 1,0,1,0 every 2 cycles then stays 1 -> no pulse during bounce; single pulse
//    6 cycles after final rising edge.
//  3 Release: after HELD, raw 1->0 with a 1-cycle glitch back to 1 -> btn_level stays 1 until 6 cycles
//    after last fall; no extra btn_press.
//  4 Ack race: press_ack[1] asserted in same cycle as btn_press[1] -> press_pending[1] remains 1; ack
//    one cycle later -> pending 0 next cycle.
//  5 Async reset mid PRESS_WAIT (count=2) -> all outputs 0 immediately; after release of reset and
//    raw still 1, pulse occurs 6 cycles after deassertion.
//  6 AUTOREPEAT_EN, raw held 40 cycles -> pulses at 6, 16, 21, 26, 31, 36, 41 (within hold+release
//    latency); without macro only cycle 6. All three buttons pressed together -> identical timing per bit.

Source files
------------

// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris button input path: channel state
// encoding, button index constants, default timing and a sizing helper.
package tetris_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } ch_state_t;

  localparam int BTN_L   = 0;
  localparam int BTN_ROT = 1;
  localparam int BTN_R   = 2;

  // Defaults sized for a 25.175 MHz pixel clock.
  localparam int DEF_N_BTN           = 3;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 251750;   // ~10 ms
  localparam int DEF_REPEAT_DELAY    = 6293750;  // ~250 ms
  localparam int DEF_REPEAT_PERIOD   = 2517500;  // ~100 ms

  // Largest of three timing constants; sizes the shared counter width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM, press pulse and sticky
// pending flag. Auto-repeat while held is built only when AUTOREPEAT_EN is
// defined; otherwise a hold produces exactly one press pulse.
module btn_debounce_ch
  import tetris_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BTN_ACTIVE_LOW  = 0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_25_175,
  input  logic reset,
  input  logic raw,
  input  logic ack,
  output logic level,
  output logic press,
  output logic pending
);

  // Counter width covers every timing constant, so saturation never truncates.
  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  // Counters start at 1 on the first qualifying sample, so compare against N-1.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  ch_state_t              state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   press_reg, press_next;
  logic                   pending_reg;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) sync_reg <= '0;
    else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
  end

  // Polarity is normalised at the synchroniser output: s = 1 means pressed.
  assign s = sync_reg[SYNC_STAGES-1] ^ (BTN_ACTIVE_LOW != 0);

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rpt_reg, rpt_next;
  logic             rpt_first_reg, rpt_first_next;

  // Repeat counter and first-interval flag.
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      rpt_reg       <= '0;
      rpt_first_reg <= 1'b1;
    end else begin
      rpt_reg       <= rpt_next;
      rpt_first_reg <= rpt_first_next;
    end
  end
`endif

  // Debounce FSM next state, counter and press pulse (plus repeat pulses).
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    press_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (s) begin
          if (DB_LAST == '0) begin
            state_next = HELD;
            press_next = 1'b1;
          end else begin
            state_next = PRESS_WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg >= DB_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end
      HELD: begin
        cnt_next = '0;
        if (!s) begin
          if (DB_LAST == '0) begin
            state_next = IDLE;
          end else begin
            state_next = RELEASE_WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg >= DB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
`ifdef AUTOREPEAT_EN
    // Runs only in HELD; RELEASE_WAIT freezes it so release bounce cannot
    // fire a repeat; cleared once the level is gone.
    rpt_next       = rpt_reg;
    rpt_first_next = rpt_first_reg;
    if (state_reg == HELD) begin
      if (rpt_reg >= (rpt_first_reg ? RD_LAST : RP_LAST)) begin
        press_next     = 1'b1;
        rpt_next       = '0;
        rpt_first_next = 1'b0;
      end else begin
        rpt_next = sat_inc(rpt_reg);
      end
    end else if (state_reg != RELEASE_WAIT) begin
      rpt_next       = '0;
      rpt_first_next = 1'b1;
    end
`endif
  end

  // State, counter and registered pulse.
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      press_reg <= press_next;
    end
  end

  // Sticky pending: a new press wins over a simultaneous acknowledge.
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) pending_reg <= 1'b0;
    else       pending_reg <= press_reg | (pending_reg & ~ack);
  end

  assign level   = (state_reg == HELD) || (state_reg == RELEASE_WAIT);
  assign press   = press_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: one independent debounce channel per button
// (bit0 = L, bit1 = rotate, bit2 = R). Define AUTOREPEAT_EN to enable
// auto-repeat press pulses while a button is held.
module button_conditioner
  import tetris_input_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BTN_ACTIVE_LOW  = 0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk_25_175,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] press_pending,
  input  logic [N_BTN-1:0] press_ack
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_25_175(clk_25_175),
      .reset     (reset),
      .raw       (btn_raw[gi]),
      .ack       (press_ack[gi]),
      .level     (btn_level[gi]),
      .press     (btn_press[gi]),
      .pending   (press_pending[gi])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner. The driver pushes the expected
// {level, press, pending} of every cycle into a queue using a history-based
// reference model; the monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int N  = 3;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] press_ack = '0;
  logic [N-1:0] btn_level, btn_press, press_pending;

  button_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_25_175   (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .press_pending(press_pending),
    .press_ack    (press_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [3*N-1:0] exp_q[$];

  // Reference model state, all describing the current cycle k.
  logic [N-1:0] m_lvl = '0, m_prs = '0, m_pnd = '0;
  logic [N-1:0] m_r1 = '0, m_r2 = '0;  // raw(k-1), raw(k-2)
  logic [N-1:0] m_sprev = '0;          // synchronised sample s(k-1)
  logic [DB-1:0] m_win[N];             // last DB synchronised samples
  int m_n[N];                          // held cycles since level rose

  function automatic bit repeat_due(input int n);
`ifdef AUTOREPEAT_EN
    return (n == RD) || (n > RD && ((n - RD) % RP) == 0);
`else
    return (n < 0);
`endif
  endfunction

  // Advance the model one clock edge given this cycle's inputs.
  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] a, input logic rs);
    logic [N-1:0] nl, np, nd;
    logic s, rep;
    if (rs) begin
      m_lvl = '0; m_prs = '0; m_pnd = '0; m_r1 = '0; m_r2 = '0; m_sprev = '0;
      for (int i = 0; i < N; i++) begin m_win[i] = '0; m_n[i] = 0; end
      return;
    end
    for (int i = 0; i < N; i++) begin
      s = m_r2[i];
      m_win[i] = {m_win[i][DB-2:0], s};
      nl[i] = m_lvl[i];
      if (!m_lvl[i] && m_win[i] == '1) nl[i] = 1'b1;
      if (m_lvl[i] && m_win[i] == '0) nl[i] = 1'b0;
      rep = 1'b0;
      if (!m_lvl[i]) m_n[i] = 0;
      else if (m_sprev[i]) begin
        m_n[i]++;
        rep = repeat_due(m_n[i]);
      end
      np[i] = (nl[i] & ~m_lvl[i]) | rep;
      nd[i] = m_prs[i] | (m_pnd[i] & ~a[i]);
      m_sprev[i] = s;
    end
    m_r2 = m_r1; m_r1 = r;
    m_lvl = nl; m_prs = np; m_pnd = nd;
  endtask

  task automatic run_cycle(input logic [N-1:0] r, input logic [N-1:0] a, input logic rs);
    @(posedge clk);
    #1;
    reset = rs; btn_raw = r; press_ack = a;
    if (rs) begin
      m_lvl = '0; m_prs = '0; m_pnd = '0;
      #1;
      vectors++;
      if ({btn_level, btn_press, press_pending} !== '0) begin
        miscompares++;
        $display("FAIL reset_clear t=%0t got level=%b press=%b pending=%b required all zero",
                 $time, btn_level, btn_press, press_pending);
      end
    end
    exp_q.push_back({m_lvl, m_prs, m_pnd});
    model_step(r, a, rs);
  endtask

  // Monitor: compare DUT outputs with the queued expectation each cycle.
  initial begin
    logic [3*N-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({btn_level, btn_press, press_pending} !== e) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t got level=%b press=%b pending=%b required level=%b press=%b pending=%b",
                   $time, btn_level, btn_press, press_pending, e[3*N-1:2*N], e[2*N-1:N], e[N-1:0]);
        end
      end
    end
  end

  initial begin
    int hold_left[N];
    logic [N-1:0] cur, a;
    for (int i = 0; i < N; i++) begin m_win[i] = '0; m_n[i] = 0; hold_left[i] = 0; end
    cur = '0;

    repeat (3) run_cycle('0, '0, 1'b1);
    repeat (4) run_cycle('0, '0, 1'b0);

    // Clean press on L, ack, release.
    repeat (12) run_cycle(3'b001, '0, 1'b0);
    run_cycle(3'b001, 3'b001, 1'b0);
    repeat (12) run_cycle('0, '0, 1'b0);

    // Bounce on press, then a release with a one-cycle glitch.
    for (int j = 0; j < 8; j++) run_cycle({2'b00, (j % 4) < 2}, '0, 1'b0);
    repeat (10) run_cycle(3'b001, '0, 1'b0);
    run_cycle('0, '0, 1'b0);
    run_cycle(3'b001, '0, 1'b0);
    repeat (10) run_cycle('0, '0, 1'b0);
    run_cycle('0, 3'b001, 1'b0);

    // Ack on rotate in the pulse cycle and the cycle after.
    for (int j = 0; j < 12; j++) run_cycle(3'b010, (j == 6 || j == 7) ? 3'b010 : 3'b000, 1'b0);
    repeat (10) run_cycle('0, '0, 1'b0);

    // Reset mid press-wait with raw still held, then reset while held and pending.
    repeat (4) run_cycle(3'b111, '0, 1'b0);
    run_cycle(3'b111, '0, 1'b1);
    repeat (12) run_cycle(3'b111, '0, 1'b0);
    run_cycle(3'b111, '0, 1'b1);
    repeat (12) run_cycle(3'b111, '0, 1'b0);
    repeat (12) run_cycle('0, '0, 1'b0);

    // All three held for 40 cycles (repeat timing when enabled).
    repeat (40) run_cycle(3'b111, '0, 1'b0);
    repeat (15) run_cycle('0, '0, 1'b0);
    run_cycle('0, 3'b111, 1'b0);

    // Randomised holds, random acks, occasional reset.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold_left[i] == 0) begin
          cur[i] = 1'($urandom_range(0, 1));
          hold_left[i] = int'($urandom_range(1, 10));
        end
        hold_left[i]--;
        a[i] = ($urandom_range(0, 3) == 0);
      end
      run_cycle(cur, a, $urandom_range(0, 399) == 0);
    end

    repeat (2) run_cycle('0, '0, 1'b0);
    @(posedge clk);
    #6;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d unchecked entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
